// File: rtl/mem_arbiter_if.sv
// Bundle of IFU, LSU and memory-side handshake signals for mem_arbiter.
// The master modport is the arbiter's view; slave is the view of the clients and memory.
interface mem_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [AW-1:0]     ifu_addr;
    logic              ifu_resp_valid;
    logic [DW-1:0]     ifu_rdata;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [AW-1:0]     lsu_addr;
    logic              lsu_wen;
    logic [DW-1:0]     lsu_wdata;
    logic [DW/8-1:0]   lsu_wmask;
    logic              lsu_resp_valid;
    logic [DW-1:0]     lsu_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [AW-1:0]     mem_addr;
    logic              mem_wen;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_wmask;
    logic              mem_resp_valid;
    logic [DW-1:0]     mem_rdata;

    modport master (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU: one outstanding transaction,
// LSU priority with an IFU anti-starvation streak limit, and a response timeout.
module mem_arbiter #(
    parameter int AW         = 64,
    parameter int DW         = 64,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.master   bus,
    output logic            owner,
    output logic            busy,
    output logic            timeout_err
);
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [CW-1:0] TMO_LAST   = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit            TMO_EN     = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [SW-1:0]    r_streak;
    logic [CW-1:0]    r_cnt;
    logic             r_owner;
    logic [AW-1:0]    r_addr;
    logic             r_wen;
    logic [DW-1:0]    r_wdata;
    logic [DW/8-1:0]  r_wmask;
    logic             r_ifu_rv;
    logic             r_lsu_rv;
    logic [DW-1:0]    r_ifu_rdata;
    logic [DW-1:0]    r_lsu_rdata;
    logic             r_timeout_err;
    logic             w_grant_ifu;
    logic             w_grant_lsu;
    logic             w_done;
    logic             w_tmo;
    logic [DW-1:0]    w_resp_data;

    // Next-state, arbitration and completion decode
    always_comb begin
        w_next      = r_state;
        w_grant_ifu = 1'b0;
        w_grant_lsu = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // IFU is forced in once LSU has won MAX_STREAK times in a row over it
                if (bus.ifu_req_valid && (r_streak == STREAK_MAX)) begin
                    w_grant_ifu = 1'b1;
                end else if (bus.lsu_req_valid) begin
                    w_grant_lsu = 1'b1;
                end else if (bus.ifu_req_valid) begin
                    w_grant_ifu = 1'b1;
                end else begin
                    w_grant_ifu = 1'b0;
                end
                if (w_grant_ifu || w_grant_lsu) begin
                    w_next = S_REQ;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_RESP: begin
                if (bus.mem_resp_valid) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end else if (TMO_EN && (r_cnt == TMO_LAST)) begin
                    w_done = 1'b1;
                    w_tmo  = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_RESP;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_resp_data = (w_tmo || (r_owner && r_wen)) ? {DW{1'b0}} : bus.mem_rdata;

    // State, latched request, streak, timeout counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_streak      <= {SW{1'b0}};
            r_cnt         <= {CW{1'b0}};
            r_owner       <= 1'b0;
            r_addr        <= {AW{1'b0}};
            r_wen         <= 1'b0;
            r_wdata       <= {DW{1'b0}};
            r_wmask       <= {(DW/8){1'b0}};
            r_ifu_rv      <= 1'b0;
            r_lsu_rv      <= 1'b0;
            r_ifu_rdata   <= {DW{1'b0}};
            r_lsu_rdata   <= {DW{1'b0}};
            r_timeout_err <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_ifu_rv <= 1'b0;
            r_lsu_rv <= 1'b0;
            if (w_grant_lsu) begin
                r_owner <= 1'b1;
                r_addr  <= bus.lsu_addr;
                r_wen   <= bus.lsu_wen;
                r_wdata <= bus.lsu_wdata;
                r_wmask <= bus.lsu_wmask;
                if (!bus.ifu_req_valid) begin
                    r_streak <= {SW{1'b0}};
                end else if (r_streak != STREAK_MAX) begin
                    r_streak <= r_streak + SW'(1);
                end else begin
                    r_streak <= r_streak;
                end
            end else if (w_grant_ifu) begin
                r_owner  <= 1'b0;
                r_addr   <= bus.ifu_addr;
                r_wen    <= 1'b0;
                r_wdata  <= {DW{1'b0}};
                r_wmask  <= {(DW/8){1'b0}};
                r_streak <= {SW{1'b0}};
            end
            if ((r_state == S_REQ) && bus.mem_req_ready) begin
                r_cnt <= {CW{1'b0}};
            end else if (r_state == S_RESP) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_done) begin
                if (r_owner) begin
                    r_lsu_rv    <= 1'b1;
                    r_lsu_rdata <= w_resp_data;
                end else begin
                    r_ifu_rv    <= 1'b1;
                    r_ifu_rdata <= w_resp_data;
                end
                if (w_tmo) begin
                    r_timeout_err <= 1'b1;
                end
            end
        end
    end

    assign bus.ifu_req_ready  = w_grant_ifu;
    assign bus.lsu_req_ready  = w_grant_lsu;
    assign bus.ifu_resp_valid = r_ifu_rv;
    assign bus.ifu_rdata      = r_ifu_rdata;
    assign bus.lsu_resp_valid = r_lsu_rv;
    assign bus.lsu_rdata      = r_lsu_rdata;
    assign bus.mem_req_valid  = (r_state == S_REQ);
    assign bus.mem_addr       = r_addr;
    assign bus.mem_wen        = r_wen;
    assign bus.mem_wdata      = r_wdata;
    assign bus.mem_wmask      = r_wmask;
    assign owner              = r_owner;
    assign busy               = (r_state != S_IDLE);
    assign timeout_err        = r_timeout_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions plus
// hand-written sequences for arbitration order, timeout and reset-in-flight.
module tb_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;

    typedef struct {
        logic        is_lsu;
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          delay;
        logic [63:0] mdata;
        logic [63:0] exp_rdata;
        logic        exp_wen;
        logic [7:0]  exp_wmask;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic owner, busy, timeout_err;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] last_ifu, last_lsu;
    vec_t vecs[4];
    vec_t v;
    logic [9:0] exp_order;
    int   n, pulses;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.ifu_req_valid = 1'b0; bus.ifu_addr = 64'd0;
        bus.lsu_req_valid = 1'b0; bus.lsu_addr = 64'd0; bus.lsu_wen = 1'b0;
        bus.lsu_wdata = 64'd0; bus.lsu_wmask = 8'd0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = 64'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        last_ifu = 64'd0;
        last_lsu = 64'd0;
    endtask

    task automatic do_txn(input vec_t t, input int idx);
        if (t.is_lsu) begin
            bus.lsu_req_valid = 1'b1; bus.lsu_addr = t.addr; bus.lsu_wen = t.wen;
            bus.lsu_wdata = t.wdata; bus.lsu_wmask = t.wmask;
        end else begin
            bus.ifu_req_valid = 1'b1; bus.ifu_addr = t.addr;
            bus.lsu_wen = t.wen; bus.lsu_wmask = t.wmask;
        end
        @(negedge clk);
        check($sformatf("v%0d_grant", idx), {62'd0, bus.ifu_req_ready, bus.lsu_req_ready},
              t.is_lsu ? 64'd1 : 64'd2);
        @(posedge clk); #1;
        // scramble the request inputs to prove the latched fields do not follow them
        bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
        bus.ifu_addr = ~t.addr; bus.lsu_addr = ~t.addr; bus.lsu_wen = ~t.wen;
        bus.lsu_wdata = ~t.wdata; bus.lsu_wmask = ~t.wmask;
        for (int i = 0; i <= t.delay; i++) begin
            bus.mem_req_ready = (i == t.delay);
            @(negedge clk);
            check($sformatf("v%0d_req_valid_c%0d", idx, i), {63'd0, bus.mem_req_valid}, 64'd1);
            check($sformatf("v%0d_addr_c%0d", idx, i), bus.mem_addr, t.addr);
            check($sformatf("v%0d_wen_c%0d", idx, i), {63'd0, bus.mem_wen}, {63'd0, t.exp_wen});
            check($sformatf("v%0d_wmask_c%0d", idx, i), {56'd0, bus.mem_wmask}, {56'd0, t.exp_wmask});
            if (t.is_lsu) begin
                check($sformatf("v%0d_wdata_c%0d", idx, i), bus.mem_wdata, t.wdata);
            end
            check($sformatf("v%0d_owner_c%0d", idx, i), {62'd0, busy, owner}, {62'd0, 1'b1, t.is_lsu});
            @(posedge clk); #1;
        end
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = t.mdata;
        @(negedge clk);
        check($sformatf("v%0d_resp_wait", idx),
              {61'd0, bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid}, 64'd0);
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0; bus.mem_rdata = 64'd0;
        @(negedge clk);
        check($sformatf("v%0d_resp_pulse", idx), {62'd0, bus.ifu_resp_valid, bus.lsu_resp_valid},
              t.is_lsu ? 64'd1 : 64'd2);
        if (t.is_lsu) begin
            last_lsu = t.exp_rdata;
        end else begin
            last_ifu = t.exp_rdata;
        end
        check($sformatf("v%0d_ifu_rdata", idx), bus.ifu_rdata, last_ifu);
        check($sformatf("v%0d_lsu_rdata", idx), bus.lsu_rdata, last_lsu);
        check($sformatf("v%0d_idle", idx), {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check($sformatf("v%0d_pulse_end", idx), {62'd0, bus.ifu_resp_valid, bus.lsu_resp_valid}, 64'd0);
        clear_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{is_lsu: 1'b0, wen: 1'b0, addr: 64'h8000_0000, wdata: 64'd0, wmask: 8'h00, delay: 0,
                    mdata: 64'h1122_3344_5566_7788, exp_rdata: 64'h1122_3344_5566_7788,
                    exp_wen: 1'b0, exp_wmask: 8'h00};
        vecs[1] = '{is_lsu: 1'b1, wen: 1'b0, addr: 64'h8000_1000, wdata: 64'd0, wmask: 8'hFF, delay: 1,
                    mdata: 64'hCAFE_BABE_0BAD_F00D, exp_rdata: 64'hCAFE_BABE_0BAD_F00D,
                    exp_wen: 1'b0, exp_wmask: 8'hFF};
        vecs[2] = '{is_lsu: 1'b1, wen: 1'b1, addr: 64'h8000_2008, wdata: 64'hDEAD_BEEF, wmask: 8'h0F, delay: 5,
                    mdata: 64'hFFFF_FFFF_FFFF_FFFF, exp_rdata: 64'd0,
                    exp_wen: 1'b1, exp_wmask: 8'h0F};
        vecs[3] = '{is_lsu: 1'b0, wen: 1'b1, addr: 64'h8000_0004, wdata: 64'd0, wmask: 8'hFF, delay: 2,
                    mdata: 64'h0000_0013_0000_0093, exp_rdata: 64'h0000_0013_0000_0093,
                    exp_wen: 1'b0, exp_wmask: 8'h00};

        do_reset();
        @(negedge clk);
        check("rst_status", {61'd0, busy, owner, timeout_err}, 64'd0);
        check("rst_ready", {62'd0, bus.ifu_req_ready, bus.lsu_req_ready}, 64'd0);
        check("rst_resp", {61'd0, bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid}, 64'd0);
        check("rst_wen", {63'd0, bus.mem_wen}, 64'd0);
        check("rst_rdata", bus.ifu_rdata | bus.lsu_rdata, 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            do_txn(vecs[i], i);
        end

        // both request together: LSU first, IFU granted in the LSU response cycle
        do_reset();
        bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 64'h42;
        bus.ifu_req_valid = 1'b1; bus.ifu_addr = 64'h8000_0000;
        bus.lsu_req_valid = 1'b1; bus.lsu_addr = 64'h8000_3000;
        @(negedge clk);
        check("both_first", {62'd0, bus.ifu_req_ready, bus.lsu_req_ready}, 64'd1);
        @(posedge clk); #1;
        bus.lsu_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("both_lsu_resp", {63'd0, bus.lsu_resp_valid}, 64'd1);
        check("both_ifu_next", {62'd0, bus.ifu_req_ready, bus.lsu_req_ready}, 64'd2);
        @(posedge clk); #1;
        clear_inputs();
        repeat (4) @(posedge clk);

        // continuous contention: L,L,L,L,I,L,L,L,L,I
        do_reset();
        exp_order = 10'b10_0001_0000;
        bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 64'h1;
        bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 10; c++) begin
            @(negedge clk);
            if (bus.ifu_req_ready || bus.lsu_req_ready) begin
                check($sformatf("order%0d", n), {62'd0, bus.ifu_req_ready, bus.lsu_req_ready},
                      exp_order[n] ? 64'd2 : 64'd1);
                n++;
            end
            @(posedge clk); #1;
        end
        check("order_count", 64'(n), 64'd10);
        clear_inputs();
        repeat (4) @(posedge clk); #1;

        // timeout: fetch with no memory response
        do_reset();
        do_txn(vecs[0], 10);
        check("tmo_err_before", {63'd0, timeout_err}, 64'd0);
        bus.ifu_req_valid = 1'b1; bus.ifu_addr = 64'h8000_0040; bus.mem_rdata = 64'h5555;
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (bus.ifu_resp_valid || bus.lsu_resp_valid) pulses++;
            @(posedge clk); #1;
        end
        check("tmo_early_pulse", 64'(pulses), 64'd0);
        @(negedge clk);
        check("tmo_pulse", {62'd0, bus.ifu_resp_valid, bus.lsu_resp_valid}, 64'd2);
        check("tmo_rdata", bus.ifu_rdata, 64'd0);
        check("tmo_err_set", {63'd0, timeout_err}, 64'd1);
        last_ifu = 64'd0;
        clear_inputs();
        @(posedge clk); #1;
        do_txn(vecs[1], 11);
        check("tmo_err_sticky", {63'd0, timeout_err}, 64'd1);

        // reset while a store waits in RESP, then a stale memory response
        bus.lsu_req_valid = 1'b1; bus.lsu_addr = 64'h8000_4000; bus.lsu_wen = 1'b1;
        bus.lsu_wdata = 64'h1234; bus.lsu_wmask = 8'hFF; bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.lsu_req_valid = 1'b0;
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        check("rip_inflight", {61'd0, busy, owner, bus.mem_wen}, 64'd7);
        @(posedge clk); #1;
        rst = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 64'h77;
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.ifu_resp_valid || bus.lsu_resp_valid) pulses++;
            @(posedge clk); #1;
            bus.mem_resp_valid = 1'b0;
        end
        @(negedge clk);
        check("rip_no_pulse", 64'(pulses), 64'd0);
        check("rip_status", {61'd0, busy, owner, timeout_err}, 64'd0);
        check("rip_mem", {62'd0, bus.mem_req_valid, bus.mem_wen}, 64'd0);
        check("rip_lsu_rdata", bus.lsu_rdata, 64'd0);
        check("rip_ifu_rdata", bus.ifu_rdata, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
